// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the FSM state encoding, the default watchdog limit and the
// function codes the control unit uses to select mult or div.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_DZERO  = 3'd4,
    S_TOUT   = 3'd5
  } state_t;

  localparam int MAX_CYCLES_DEFAULT = 40;

  localparam logic [5:0] FUN_MULT = 6'h18;
  localparam logic [5:0] FUN_DIV  = 6'h1a;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake/data bundle between the control unit, the sequencer and the
// multiplier/divider units.
//   slave  : sequencer side (takes start/operands/stops, drives launches,
//            latched operands, HI/LO write controls and status)
//   master : control-unit / unit side (the opposite directions)
interface muldiv_sequencer_if;
  logic        start;
  logic        op_div;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mult_control;
  logic        div_control;
  logic        mult_stop;
  logic        div_stop;
  logic        HiLo_load;
  logic        sel_mux_hi;
  logic        sel_mux_lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        timeout;

  modport slave (
    input  start, op_div, a_in, b_in, mult_stop, div_stop,
    output op_a, op_b, mult_control, div_control, HiLo_load,
           sel_mux_hi, sel_mux_lo, busy, done, div_zero, timeout
  );

  modport master (
    output start, op_div, a_in, b_in, mult_stop, div_stop,
    input  op_a, op_b, mult_control, div_control, HiLo_load,
           sel_mux_hi, sel_mux_lo, busy, done, div_zero, timeout
  );
endinterface

// File: rtl/muldiv_sequencer_watchdog.sv
// Watchdog cycle counter for the WAIT state.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count one cycle
//   tc         : count has reached MAX_CYCLES-1
module muldiv_watchdog #(
  parameter int MAX_CYCLES = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      // Saturate so a stop that wins the race on the last count cannot wrap.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: accepts a one-cycle start from the control
// unit, launches the multiplier or divider, waits for its completion pulse
// (guarded by a watchdog) and then writes HI/LO. Division by zero is caught
// up front without launching the divider. All outputs are registered and
// decoded from the next state, so they line up with the state register.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : handshake/data bundle (slave side)
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_q, op_d;
  logic        sel_q, sel_d;
  logic        mult_ctl_q, mult_ctl_d;
  logic        div_ctl_q, div_ctl_d;
  logic        load_q, load_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dzero_q, dzero_d;
  logic        tout_q, tout_d;
  logic        wd_tc;
  logic        stop_match;

  muldiv_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == S_LAUNCH),
    .en    (state_q == S_WAIT),
    .tc    (wd_tc)
  );

  // Only the completion pulse of the unit actually launched counts.
  assign stop_match = op_q ? bus.div_stop : bus.mult_stop;

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_a_d  = bus.a_in;
          op_b_d  = bus.b_in;
          op_d    = bus.op_div;
          state_d = (bus.op_div && (bus.b_in == '0)) ? S_DZERO : S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // A matching stop on the terminal count still completes normally.
        if (stop_match)  state_d = S_WRITE;
        else if (wd_tc)  state_d = S_TOUT;
      end
      S_WRITE:  state_d = S_IDLE;
      S_DZERO:  state_d = S_IDLE;
      S_TOUT:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    mult_ctl_d = (state_d == S_LAUNCH) && !op_d;
    div_ctl_d  = (state_d == S_LAUNCH) &&  op_d;
    load_d     = (state_d == S_WRITE);
    done_d     = (state_d == S_WRITE);
    dzero_d    = (state_d == S_DZERO);
    tout_d     = (state_d == S_TOUT);
    busy_d     = (state_d != S_IDLE);
    sel_d      = (state_d == S_WRITE) ? op_d : sel_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_q       <= 1'b0;
      sel_q      <= 1'b0;
      mult_ctl_q <= 1'b0;
      div_ctl_q  <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dzero_q    <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      mult_ctl_q <= mult_ctl_d;
      div_ctl_q  <= div_ctl_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dzero_q    <= dzero_d;
      tout_q     <= tout_d;
    end
  end

  assign bus.op_a         = op_a_q;
  assign bus.op_b         = op_b_q;
  assign bus.mult_control = mult_ctl_q;
  assign bus.div_control  = div_ctl_q;
  assign bus.HiLo_load    = load_q;
  assign bus.sel_mux_hi   = sel_q;
  assign bus.sel_mux_lo   = sel_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.div_zero     = dzero_q;
  assign bus.timeout      = tout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard testbench for muldiv_sequencer: each operation pushes its
// expected completion (kind, cycle, operands, mux select, launch pulses)
// into a queue; a monitor pops and compares on every completion pulse.
module tb_muldiv_sequencer;

  localparam int MAX = 40;
  localparam int K_DONE = 0, K_DZ = 1, K_TOUT = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        sel;
    int          nm;
    int          nd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_sel = 1'b0;
  exp_t exp_q[$];

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.MAX_CYCLES(MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts launch pulses and checks every completion against the queue.
  initial begin
    int   nm;
    int   nd;
    exp_t e;
    nm = 0;
    nd = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        nm = 0;
        nd = 0;
      end else begin
        if (bus.mult_control) nm++;
        if (bus.div_control)  nd++;
        if (bus.done || bus.div_zero || bus.timeout || bus.HiLo_load) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got done=%0b dz=%0b to=%0b load=%0b expected none",
                     bus.done, bus.div_zero, bus.timeout, bus.HiLo_load);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", {bus.done, bus.div_zero, bus.timeout, bus.HiLo_load},
                  {e.kind == K_DONE, e.kind == K_DZ, e.kind == K_TOUT, e.kind == K_DONE});
            check("event_cycle", cyc, e.cyc);
            check("op_a", bus.op_a, e.opa);
            check("op_b", bus.op_b, e.opb);
            check("sel_mux", {bus.sel_mux_hi, bus.sel_mux_lo}, {e.sel, e.sel});
            check("launch_pulses", {nm[7:0], nd[7:0]}, {e.nm[7:0], e.nd[7:0]});
            check("busy_at_event", bus.busy, 1'b1);
          end
          nm = 0;
          nd = 0;
        end
      end
    end
  end

  // k  : WAIT-cycle index (1..MAX) carrying the matching stop, 0 = never
  // wk : WAIT-cycle index of a non-matching stop, 0 = none
  // bk : WAIT-cycle index of an ignored start with a_in=99, 0 = none
  // sl : stray matching stop during the launch cycle
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input int k, input int wk, input int bk, input logic sl);
    exp_t e;
    int   n;
    int   fin;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = op;
    bus.a_in   = a;
    bus.b_in   = b;
    n      = cyc + 1;
    e.opa  = a;
    e.opb  = b;
    fin    = 0;
    if (op && (b == 0)) begin
      e.kind = K_DZ;  e.cyc = n; e.nm = 0; e.nd = 0; e.sel = last_sel;
    end else begin
      e.nm = op ? 0 : 1;
      e.nd = op ? 1 : 0;
      if (k >= 1 && k <= MAX) begin
        e.kind = K_DONE; e.cyc = n + 1 + k; e.sel = op; last_sel = op; fin = k;
      end else begin
        e.kind = K_TOUT; e.cyc = n + 1 + MAX; e.sel = last_sel; fin = MAX;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = $urandom;
    bus.b_in  = $urandom;
    check("busy_after_start", bus.busy, 1'b1);
    if (e.kind != K_DZ) begin
      for (int t = 1; t <= fin + 1; t++) begin
        if (t == 1 && sl) begin
          if (op) bus.div_stop = 1'b1; else bus.mult_stop = 1'b1;
        end
        if (k >= 1 && t - 1 == k) begin
          if (op) bus.div_stop = 1'b1; else bus.mult_stop = 1'b1;
        end
        if (wk > 0 && t - 1 == wk) begin
          if (op) bus.mult_stop = 1'b1; else bus.div_stop = 1'b1;
        end
        if (bk > 0 && t - 1 == bk) begin
          bus.start  = 1'b1;
          bus.op_div = 1'($urandom_range(0, 1));
          bus.a_in   = 32'd99;
          bus.b_in   = $urandom;
        end
        @(negedge clk);
        bus.mult_stop = 1'b0;
        bus.div_stop  = 1'b0;
        bus.start     = 1'b0;
      end
    end
    @(negedge clk);
    check("busy_after_op", bus.busy, 1'b0);
    check("op_a_hold", bus.op_a, a);
  endtask

  initial begin
    logic        op;
    logic [31:0] b;
    int          k, wk, bk, lim;
    bus.start = 0; bus.op_div = 0; bus.a_in = 0; bus.b_in = 0;
    bus.mult_stop = 0; bus.div_stop = 0;
    #1;
    check("reset_outputs", {bus.op_a, bus.op_b, bus.mult_control, bus.div_control, bus.HiLo_load,
                            bus.sel_mux_hi, bus.sel_mux_lo, bus.busy, bus.done, bus.div_zero,
                            bus.timeout}, 75'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(1'b0, 32'd7, 32'd6, 5, 0, 0, 1'b0);     // mult 7*6
    run_op(1'b1, 32'd10, 32'd0, 0, 0, 0, 1'b0);    // div by zero
    run_op(1'b1, 32'd10, 32'd3, 0, 0, 0, 1'b0);    // timeout
    run_op(1'b0, 32'd12, 32'd5, 5, 3, 2, 1'b1);    // ignored stop/start
    run_op(1'b1, 32'd10, 32'd3, MAX, 0, 0, 1'b0);  // stop on terminal count
    run_op(1'b1, 32'd20, 32'd4, 1, 0, 0, 1'b0);    // fastest completion

    // Reset in the middle of a div WAIT: aborts silently.
    @(negedge clk);
    bus.start = 1'b1; bus.op_div = 1'b1; bus.a_in = 32'd10; bus.b_in = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    last_sel = 1'b0;
    #1;
    check("async_reset_outputs", {bus.op_a, bus.op_b, bus.mult_control, bus.div_control,
                                  bus.HiLo_load, bus.sel_mux_hi, bus.sel_mux_lo, bus.busy,
                                  bus.done, bus.div_zero, bus.timeout}, 75'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.div_stop = 1'b1;
    @(negedge clk);
    bus.div_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {bus.busy, bus.op_a}, 33'd0);

    for (int i = 0; i < 40; i++) begin
      op  = 1'($urandom_range(0, 1));
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      k   = $urandom_range(0, 9);
      k   = (k == 0) ? 0 : (k == 1) ? MAX : $urandom_range(1, 12);
      lim = (k == 0) ? MAX : k - 1;
      wk  = (lim >= 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, lim) : 0;
      bk  = (lim >= 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, lim) : 0;
      run_op(op, $urandom, b, k, wk, bk, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL sim_timeout: got no finish expected finish by 400000");
    $fatal(1, "time limit");
  end

endmodule
